// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a load-store unit and data_memory_ctrl.
// master: the requester (drives requests, consumes responses).
// slave:  the memory controller.
interface data_memory_ctrl_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        WE;
  logic [2:0]  Type;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RD;
  logic [1:0]  A;
  logic [2:0]  TypeOut;
  logic        Fault;

  modport master (
    output ReqValid, WE, Type, Addr, WD, RspReady,
    input  ReqReady, RspValid, RD, A, TypeOut, Fault
  );

  modport slave (
    input  ReqValid, WE, Type, Addr, WD, RspReady,
    output ReqReady, RspValid, RD, A, TypeOut, Fault
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Single-port data memory controller with a valid/ready request and response
// handshake. One request in flight at a time: IDLE -> BUSY -> RESP -> IDLE,
// misaligned requests skip BUSY and answer with Fault=1.
// Loads return the whole aligned word; byte/half extraction is left to the
// consumer using A and TypeOut.
// Optional macro DMEM_WAIT_EN: stretches BUSY to WAIT_CYCLES+1 cycles.
module data_memory_ctrl #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic               CLK,
  input logic               RSTn,
  data_memory_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        r_state;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_fault;
  logic          r_we;
  logic [2:0]    r_type;
  logic [1:0]    r_a;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wd;
  logic [31:0]   r_rd;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req_fault;
  logic          w_busy_done;
  logic          w_commit;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;

  // Misalignment of the offered request: half on odd byte, word off a word boundary.
  assign w_req_fault = ((bus.Type[1:0] == 2'b01) && bus.Addr[0]) ||
                       ((bus.Type[1:0] == 2'b10) && (bus.Addr[1:0] != 2'b00));

  // Store commits on the BUSY -> RESP edge only.
  assign w_commit = (r_state == BUSY) && w_busy_done && r_we;

`ifdef DMEM_WAIT_EN
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] r_wait_cnt;

  assign w_busy_done = (r_wait_cnt == '0);

  // Down-counter loaded at accept; BUSY ends once it reaches zero.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wait_cnt <= '0;
    end else if ((r_state == IDLE) && bus.ReqValid && !w_req_fault) begin
      r_wait_cnt <= CW'(WAIT_CYCLES);
    end else if ((r_state == BUSY) && !w_busy_done) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end
`else
  assign w_busy_done = 1'b1;
`endif

  // Byte enables and lane-replicated store data from the captured request.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    w_be    = 4'b1111;
    w_wdata = r_wd;
    case (r_type[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_a;
        w_wdata = {4{r_wd[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {r_a[1], 1'b0};
        w_wdata = {2{r_wd[15:0]}};
      end
      default: ;
    endcase
  end

  // Memory array write port, byte-lane masked.
  // NOTE: the array is deliberately not reset: contents survive RSTn and it maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_fault     <= 1'b0;
      r_we        <= 1'b0;
      r_type      <= '0;
      r_a         <= '0;
      r_idx       <= '0;
      r_wd        <= '0;
      r_rd        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.ReqValid) begin
            r_we        <= bus.WE;
            r_type      <= bus.Type;
            r_a         <= bus.Addr[1:0];
            r_idx       <= bus.Addr[AW+1:2];
            r_wd        <= bus.WD;
            r_fault     <= w_req_fault;
            r_req_ready <= 1'b0;
            if (w_req_fault) begin
              r_rd        <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_state     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (w_busy_done) begin
            r_rd        <= r_we ? '0 : r_mem[r_idx];
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.RspReady) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ReqReady = r_req_ready;
  assign bus.RspValid = r_rsp_valid;
  assign bus.RD       = r_rd;
  assign bus.A        = r_a;
  assign bus.TypeOut  = r_type;
  assign bus.Fault    = r_fault;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl. A word-level memory model plus an
// expected-response queue predicts every response; a negedge monitor compares
// each RESP cycle, and directed literals pin the model on the key scenarios.
module tb_data_memory_ctrl;
  localparam int DEPTH = 256;
  localparam int WAIT  = 2;
`ifdef DMEM_WAIT_EN
  localparam int BUSY_LEN = WAIT + 1;
  localparam int LAT_LIT  = 4;
`else
  localparam int BUSY_LEN = 1;
  localparam int LAT_LIT  = 2;
`endif
  localparam int LAT = BUSY_LEN + 1;

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_W3 = 3'b011;
  localparam logic [2:0] T_BU = 3'b100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_ctrl_if bus();

  data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic        we;
    logic [2:0]  t;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        f;
    logic [31:0] rd;
    bit          rd_known;
  } exp_t;

  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  exp_t        q[$];

  int ncyc = 0, accept_n = 0, n_accepts = 0, last_gap = 0, last_lat = 0;
  bit in_rsp = 0;
  logic [31:0] last_rd;
  logic [1:0]  last_a;
  logic [2:0]  last_t;
  logic        last_f;

  function automatic bit is_fault(logic [2:0] t, logic [31:0] a);
    return ((t[1:0] == 2'b01) && a[0]) || ((t[1:0] == 2'b10) && (a[1:0] != 2'b00));
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) & 32'(DEPTH - 1));
  endfunction

  task automatic model_store(exp_t e);
    int w;
    w = widx(e.addr);
    case (e.t[1:0])
      2'b00:   m_mem[w][8*e.addr[1:0] +: 8] = e.wd[7:0];
      2'b01:   m_mem[w][16*e.addr[1] +: 16] = e.wd[15:0];
      default: begin m_mem[w] = e.wd; m_known[w] = 1'b1; end
    endcase
  endtask

  // Monitor: predict at accept, compare every response cycle, retire on handshake.
  always @(negedge clk) begin
    exp_t e;
    int   w;
    ncyc++;
    if (!rst_n) begin
      q.delete();
      in_rsp = 0;
    end else begin
      if (bus.RspValid) begin
        if (q.size() == 0) begin
          check("rsp_without_req", 32'd1, 32'd0);
        end else begin
          e = q[0];
          if (!in_rsp) begin
            last_lat = ncyc - accept_n;
            check("latency", 32'(last_lat), e.f ? 32'd1 : 32'(LAT));
            in_rsp = 1;
          end
          if (e.rd_known) check("rd", bus.RD, e.rd);
          check("a", 32'(bus.A), 32'(e.addr[1:0]));
          check("type_out", 32'(bus.TypeOut), 32'(e.t));
          check("fault", 32'(bus.Fault), 32'(e.f));
          check("req_ready_in_resp", 32'(bus.ReqReady), 32'd0);
          if (bus.RspReady) begin
            last_rd = bus.RD; last_a = bus.A; last_t = bus.TypeOut; last_f = bus.Fault;
            if (e.we && !e.f) model_store(e);
            void'(q.pop_front());
            in_rsp = 0;
          end
        end
      end
      if (bus.ReqValid && bus.ReqReady) begin
        e.we   = bus.WE;
        e.t    = bus.Type;
        e.addr = bus.Addr;
        e.wd   = bus.WD;
        e.f    = is_fault(bus.Type, bus.Addr);
        w      = widx(bus.Addr);
        e.rd       = (e.we || e.f) ? 32'd0 : m_mem[w];
        e.rd_known = e.we || e.f || m_known[w];
        q.push_back(e);
        n_accepts++;
        last_gap = ncyc - accept_n;
        accept_n = ncyc;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(logic we, logic [2:0] t, logic [31:0] addr, logic [31:0] wd);
    int n = 0;
    @(posedge clk); #1;
    bus.ReqValid = 1'b1; bus.WE = we; bus.Type = t; bus.Addr = addr; bus.WD = wd;
    while (!bus.ReqReady && n < 100) begin @(posedge clk); #1; n++; end
    if (!bus.ReqReady) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    bus.WE = 1'($urandom); bus.Type = 3'($urandom); bus.Addr = $urandom; bus.WD = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || !bus.ReqReady) && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic xact(logic we, logic [2:0] t, logic [31:0] addr, logic [31:0] wd);
    send(we, t, addr, wd);
    wait_done();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req_ready"}, 32'(bus.ReqReady), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus.RspValid), 32'd0);
    check({tag, "_rd"},        bus.RD,            32'd0);
    check({tag, "_a"},         32'(bus.A),        32'd0);
    check({tag, "_type_out"},  32'(bus.TypeOut),  32'd0);
    check({tag, "_fault"},     32'(bus.Fault),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc0;
    bus.ReqValid = 1'b0; bus.WE = 1'b0; bus.Type = '0; bus.Addr = '0; bus.WD = '0;
    bus.RspReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk) rst_n = 1'b1;

    // Word store then load
    xact(1'b1, T_W, 32'h10, 32'hDEADBEEF);
    xact(1'b0, T_W, 32'h10, 32'h0);
    check("lw10_rd", last_rd, 32'hDEADBEEF);
    check("lw10_a", 32'(last_a), 32'd0);
    check("lw10_type", 32'(last_t), 32'(3'b010));
    check("lw10_fault", 32'(last_f), 32'd0);
    check("lw10_lat", 32'(last_lat), 32'(LAT_LIT));

    // Byte and half stores merged into a zero word
    xact(1'b1, T_W, 32'h10, 32'h0);
    xact(1'b1, T_B, 32'h13, 32'h000000A5);
    xact(1'b0, T_W, 32'h10, 32'h0);
    check("sb13_rd", last_rd, 32'hA5000000);
    xact(1'b1, T_H, 32'h12, 32'h00001234);
    xact(1'b0, T_W, 32'h10, 32'h0);
    check("sh12_rd", last_rd, 32'h12340000);

    // Misaligned half load faults with a one-cycle response
    xact(1'b0, T_H, 32'h11, 32'h0);
    check("lh11_fault", 32'(last_f), 32'd1);
    check("lh11_rd", last_rd, 32'd0);
    check("lh11_lat", 32'(last_lat), 32'd1);
    check("lh11_a", 32'(last_a), 32'd1);
    xact(1'b0, T_W, 32'h10, 32'h0);
    check("after_fault_rd", last_rd, 32'h12340000);

    // Type 011 is word width; unsigned byte load returns the raw word
    xact(1'b1, T_W3, 32'h14, 32'hCAFEF00D);
    xact(1'b0, T_BU, 32'h15, 32'h0);
    check("lbu15_rd", last_rd, 32'hCAFEF00D);
    check("lbu15_a", 32'(last_a), 32'd1);
    check("lbu15_type", 32'(last_t), 32'(3'b100));
    xact(1'b1, T_W, 32'h16, 32'hFFFFFFFF);
    check("sw16_fault", 32'(last_f), 32'd1);
    xact(1'b0, T_W, 32'h14, 32'h0);
    check("after_sw16_rd", last_rd, 32'hCAFEF00D);

    // Address wraps modulo DEPTH words
    xact(1'b0, T_W, 32'h410, 32'h0);
    check("lw410_rd", last_rd, 32'h12340000);

    // Reset during BUSY aborts the store
    xact(1'b1, T_W, 32'h20, 32'h11112222);
    send(1'b1, T_W, 32'h20, 32'hFFFFFFFF);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("busy_rst");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    xact(1'b0, T_W, 32'h20, 32'h0);
    check("lw20_after_rst", last_rd, 32'h11112222);

    // Consumer stall with a competing request held on the bus
    bus.RspReady = 1'b0;
    send(1'b0, T_W, 32'h10, 32'h0);
    n = 0;
    while (!bus.RspValid && n < 50) begin @(posedge clk); #1; n++; end
    check("stall_rsp_seen", 32'(bus.RspValid), 32'd1);
    bus.ReqValid = 1'b1; bus.WE = 1'b1; bus.Type = T_W; bus.Addr = 32'h10; bus.WD = 32'h0;
    acc0 = n_accepts;
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_rsp_valid", 32'(bus.RspValid), 32'd1);
      check("stall_rd", bus.RD, 32'h12340000);
      check("stall_req_ready", 32'(bus.ReqReady), 32'd0);
    end
    check("stall_no_accept", 32'(n_accepts), 32'(acc0));
    bus.ReqValid = 1'b0;
    bus.RspReady = 1'b1;
    wait_done();
    check("stall_last_rd", last_rd, 32'h12340000);
    xact(1'b0, T_W, 32'h10, 32'h0);
    check("after_stall_rd", last_rd, 32'h12340000);

    // Back-to-back requests: accept spacing is 2 + BUSY length
    send(1'b0, T_W, 32'h14, 32'h0);
    send(1'b0, T_W, 32'h10, 32'h0);
    wait_done();
    check("throughput_gap", 32'(last_gap), 32'(LAT_LIT + 1));
    check("b2b_rd", last_rd, 32'h12340000);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra access latency in cycles when DMEM_WAIT_EN is defined.
REQ-003 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port RSTn  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports ReqValid in 1 (request offered) and ReqReady out 1 (request accepted when both high).
REQ-006 SHALL have ports WE in 1 (1 = store), Type in 3 (funct3 width code), Addr in 32 (byte address), WD in 32 (store data).
REQ-007 SHALL have ports RspValid out 1 (response available) and RspReady in 1 (consumer takes response).
REQ-008 SHALL have ports RD out 32 (raw aligned word), A out 2 (Addr[1:0] of request), TypeOut out 3 (Type of request), Fault out 1 (misaligned request).

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, RESP; ReqReady = 1 only in IDLE.
REQ-010 SHALL capture WE, Type, Addr, WD on the accept edge (ReqValid & ReqReady) and move IDLE->BUSY, or IDLE->RESP for faulted requests.
REQ-011 SHALL flag Fault when Type[1:0]=01 and Addr[0]=1, or Type[1:0]=10 and Addr[1:0]!=00; faulted requests perform no memory access and return RD=0.
REQ-012 SHALL treat Type[1:0]=11 as word width.
REQ-013 SHALL index memory with Addr[log2(DEPTH)+1:2]; higher address bits ignored (wrap modulo DEPTH words).
REQ-014 SHALL form byte enables: byte 0001<<A, half 0011<<{A[1],0}, word 1111; store data replicated onto all lanes (byte x4, half x2).
REQ-015 SHALL commit a store write only on the BUSY->RESP edge; stores return RD=0, Fault=0.
REQ-016 SHALL return for loads the full unmodified memory word in RD, with A and TypeOut from the request, for downstream extraction/sign-extension.
REQ-017 SHALL assert RspValid exactly in RESP and hold RD, A, TypeOut, Fault stable until RspReady; RESP->IDLE on RspValid & RspReady.
REQ-018 SHALL not accept a new request in the RESP->IDLE cycle; maximum throughput one request per (2 + BUSY length) cycles.
REQ-019 SHALL treat ReqValid high with RspReady held low as stall: FSM stays in RESP indefinitely, no state or memory change.
REQ-020 SHALL ignore request inputs outside the accept cycle.

Reset
REQ-021 SHALL on RSTn low force state IDLE, ReqReady=1, RspValid=0, RD=0, A=0, TypeOut=0, Fault=0, wait counter=0.
REQ-022 SHALL abort any in-flight request on reset with no memory write; memory contents are not reset.

Configuration
REQ-023 SHALL use macro DMEM_WAIT_EN: defined -> BUSY lasts WAIT_CYCLES+1 cycles via down-counter, RspValid first high WAIT_CYCLES+2 cycles after accept edge.
REQ-024 SHALL without DMEM_WAIT_EN hold BUSY exactly 1 cycle (no counter), RspValid first high 2 cycles after accept edge; WAIT_CYCLES ignored.

Verification
REQ-025 SHALL check store word WD=0xDEADBEEF @0x10, then load word @0x10 -> RD=0xDEADBEEF, A=00, TypeOut=010, Fault=0.
REQ-026 SHALL check store byte WD=0x000000A5 @0x13 over 0x00000000 word, load word @0x10 -> RD=0xA5000000; store half 0x1234 @0x12 -> RD=0x12340000.
REQ-027 SHALL check load half @0x11 -> Fault=1, RD=0, response one cycle after accept, memory unchanged.
REQ-028 SHALL check RspReady low for 5 cycles in RESP -> RspValid and RD stable, ReqReady=0, second ReqValid not accepted.
REQ-029 SHALL check reset asserted while BUSY on a store of 0xFFFFFFFF @0x20 -> outputs at reset values, later load @0x20 returns prior contents.
REQ-030 SHALL check latency with and without DMEM_WAIT_EN (WAIT_CYCLES=2): RspValid 4 vs 2 cycles after accept; load @0x410 with DEPTH=256 returns word at 0x010.
